spi_master_arb: RTL and testbench

Two-port SPI master that arbitrates between two on-chip requesters and serialises their register accesses onto one SPI link to the slave register controller.
- Frame is 14 bits, LSB first: addr[4:0], then mode (1 = write, 0 = read), then data[7:0].
- Write frames drive data on MOSI; read frames capture data from MISO.
- Round-robin arbitration, one transaction in flight, programmable SCLK divider and inter-frame CS gap.

---
 rtl/spi_master_arb_if.sv | 19 +
 rtl/spi_master_arb.sv | 142 ++++++++++++++
 tb/tb_spi_master_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: requester handshakes and SPI link bundle for spi_master_arb
interface spi_master_arb_if;
  logic       req0, we0, ack0, done0;
  logic [4:0] addr0;
  logic [7:0] wdata0;
  logic       req1, we1, ack1, done1;
  logic [4:0] addr1;
  logic [7:0] wdata1;
  logic [7:0] rdata;
  logic       SCLK, CS_n, MOSI, MISO;
  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, MISO,
    output ack0, done0, ack1, done1, rdata, SCLK, CS_n, MOSI
  );
  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, MISO,
    input  ack0, done0, ack1, done1, rdata, SCLK, CS_n, MOSI
  );
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin two-port SPI master serialising 14-bit LSB-first frames
module spi_master_arb #(
  parameter int CLK_DIV = 2,
  parameter int GAP     = 2
) (
  input logic              clk,
  input logic              rst,
  spi_master_arb_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TAIL, S_GAP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [12:0] sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  rise_q, rise_d;
  logic [7:0]  gap_q, gap_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        tick, win, arb;
  logic [13:0] frame;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.rdata = rdata_q;
  assign bus.SCLK  = sclk_q;
  assign bus.CS_n  = cs_n_q;
  assign bus.MOSI  = mosi_q;
  // next-state: arbitration, SCLK divider, frame shifting and read capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    div_d   = div_q;
    rise_d  = rise_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    arb     = 1'b0;
    tick    = div_q == DIV_M1;
    win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    frame   = win ? {bus.we1 ? bus.wdata1 : 8'h00, bus.we1, bus.addr1}
                  : {bus.we0 ? bus.wdata0 : 8'h00, bus.we0, bus.addr0};
    if (state_q == S_SHIFT || state_q == S_TAIL) div_d = tick ? 8'd0 : div_q + 8'd1;
    unique case (state_q)
      S_IDLE: arb = 1'b1;
      S_SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rise_d  = rise_q + 4'd1;
          rx_d    = {bus.MISO, rx_q[7:1]};
          state_d = rise_q == 4'd13 ? S_TAIL : S_SHIFT;
        end else begin
          mosi_d = sh_q[0];
          sh_d   = {1'b0, sh_q[12:1]};
        end
      end
      S_TAIL: if (tick) begin
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done0_d = ~last_q;
        done1_d = last_q;
        rdata_d = we_q ? rdata_q : rx_q;
        gap_d   = GAP_M1;
        state_d = S_GAP;
      end
      S_GAP: begin
        arb     = gap_q == 8'd0;
        gap_d   = arb ? gap_q : gap_q - 8'd1;
        state_d = arb ? S_IDLE : S_GAP;
      end
    endcase
    if (arb && (bus.req0 || bus.req1)) begin
      state_d = S_SHIFT;
      last_d  = win;
      ack0_d  = ~win;
      ack1_d  = win;
      we_d    = frame[5];
      sh_d    = frame[13:1];
      mosi_d  = frame[0];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      div_d   = 8'd0;
      rise_d  = 4'd0;
    end
  end
  // state register with synchronous reset that aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      div_q   <= '0;
      rise_q  <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      rise_q  <= rise_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: table-driven scoreboard bench for spi_master_arb
module tb_spi_master_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_arb_if a();
  spi_master_arb_if b();
  spi_master_arb #(.CLK_DIV(2), .GAP(2)) dut_a (.clk(clk), .rst(rst), .bus(a));
  spi_master_arb #(.CLK_DIV(1), .GAP(1)) dut_b (.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  sd;
    logic [13:0] frame;
    logic [7:0]  rd;
  } vec_t;
  typedef struct {
    logic        port;
    logic [13:0] frame;
    logic [7:0]  rd;
    logic [7:0]  sd;
  } exp_t;
  exp_t  sbq[$];
  vec_t  tbl[6];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    ma_nr = 0, ma_at = 0, ma_dt = -1;
  logic  ma_sp = 1'b0;
  logic [13:0] ma_cap = '0;
  logic [7:0]  ma_sd = '0;
  exp_t  ma_e;
  int    mb_nr = 0, mb_at = 0, mb_dt = 0, mb_lr = 0, mb_acks = 0, mb_dones = 0;
  logic  mb_sp = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask
  task automatic drive(vec_t v);
    @(negedge clk);
    if (v.port) begin
      a.req1 = 1'b1; a.we1 = v.we; a.addr1 = v.addr; a.wdata1 = v.wd;
    end else begin
      a.req0 = 1'b1; a.we0 = v.we; a.addr0 = v.addr; a.wdata0 = v.wd;
    end
    sbq.push_back('{v.port, v.frame, v.rd, v.sd});
  endtask
  task automatic wait_idle(int lim);
    int k = 0;
    while (sbq.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("sb_drained", sbq.size(), 0);
  endtask
  // DUT A monitor and SPI slave: frame capture, MISO drive, scoreboard compare
  initial forever begin
    @(negedge clk);
    if (rst) begin
      ma_nr = 0; ma_sp = 1'b0; a.MISO = 1'b0;
    end else begin
      if (a.ack0 | a.ack1) begin
        check("ack_onehot", $countones({a.ack0, a.ack1, a.done0, a.done1}), 1);
        check("ack_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          check("ack_port", a.ack1, sbq[0].port);
          ma_sd = sbq[0].sd;
        end
        if (ma_dt >= 0) check("gap_ge", (cyc - ma_dt) >= 2, 1);
        check("cs_low_at_ack", a.CS_n, 0);
        ma_at = cyc; ma_nr = 0; ma_cap = '0; a.MISO = 1'b0;
      end
      if (a.SCLK && !ma_sp) begin
        if (ma_nr < 14) ma_cap[ma_nr] = a.MOSI;
        ma_nr++;
        if (ma_nr >= 6 && ma_nr <= 13) a.MISO = ma_sd[ma_nr - 6];
      end
      ma_sp = a.SCLK;
      if (a.done0 | a.done1) begin
        check("done_onehot", $countones({a.ack0, a.ack1, a.done0, a.done1}), 1);
        check("done_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          ma_e = sbq.pop_front();
          check("done_port", a.done1, ma_e.port);
          check("frame", ma_cap, ma_e.frame);
          check("rises", ma_nr, 14);
          check("rdata", a.rdata, ma_e.rd);
          check("ack_done_lat", cyc - ma_at, 56);
          check("cs_high_at_done", a.CS_n, 1);
          check("mosi_idle_at_done", a.MOSI, 0);
        end
        ma_dt = cyc;
      end
    end
  end
  // DUT B monitor: SCLK period and back-to-back latency at the fastest settings
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (b.ack0) begin
        if (mb_dones > 0) check("b_ack_after_done", cyc - mb_dt, 1);
        mb_at = cyc; mb_nr = 0; mb_acks++;
      end
      if (b.SCLK && !mb_sp) begin
        check("b_sclk_period", cyc - (mb_nr == 0 ? mb_at : mb_lr), mb_nr == 0 ? 1 : 2);
        mb_lr = cyc; mb_nr++;
      end
      if (b.done0) begin
        check("b_ack_done", cyc - mb_at, 28);
        check("b_rises", mb_nr, 14);
        mb_dt = cyc; mb_dones++;
      end
    end
    mb_sp = b.SCLK;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    a.req0 = 0; a.we0 = 0; a.addr0 = 0; a.wdata0 = 0;
    a.req1 = 0; a.we1 = 0; a.addr1 = 0; a.wdata1 = 0; a.MISO = 0;
    b.req0 = 0; b.we0 = 0; b.addr0 = 0; b.wdata0 = 0;
    b.req1 = 0; b.we1 = 0; b.addr1 = 0; b.wdata1 = 0; b.MISO = 0;
    tbl[0] = '{1'b0, 1'b1, 5'h0A, 8'hC3, 8'h00, 14'h30EA, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 5'h1F, 8'hFF, 8'h5A, 14'h001F, 8'h5A};
    tbl[2] = '{1'b0, 1'b1, 5'h11, 8'h3C, 8'h99, 14'h0F31, 8'h5A};
    tbl[3] = '{1'b1, 1'b0, 5'h03, 8'h00, 8'hA5, 14'h0003, 8'hA5};
    tbl[4] = '{1'b0, 1'b0, 5'h00, 8'h77, 8'h01, 14'h0000, 8'h01};
    tbl[5] = '{1'b1, 1'b1, 5'h15, 8'h80, 8'hFF, 14'h2035, 8'h01};
    repeat (2) @(negedge clk);
    check("rst_cs_n", a.CS_n, 1);
    check("rst_sclk", a.SCLK, 0);
    check("rst_mosi", a.MOSI, 0);
    check("rst_rdata", a.rdata, 0);
    check("rst_ack_done", {a.ack0, a.ack1, a.done0, a.done1}, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check("ack_lat1", tbl[i].port ? a.ack1 : a.ack0, 1);
      if (tbl[i].port) begin
        a.req1 = 0; a.we1 = ~tbl[i].we; a.addr1 = ~tbl[i].addr; a.wdata1 = ~tbl[i].wd;
      end else begin
        a.req0 = 0; a.we0 = ~tbl[i].we; a.addr0 = ~tbl[i].addr; a.wdata0 = ~tbl[i].wd;
      end
      wait_idle(300);
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a.req0 = 1; a.we0 = 1; a.addr0 = 5'h01; a.wdata0 = 8'h11;
    a.req1 = 1; a.we1 = 1; a.addr1 = 5'h02; a.wdata1 = 8'h22;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back('{1'b0, 14'h0461, 8'h00, 8'h00});
      sbq.push_back('{1'b1, 14'h08A2, 8'h00, 8'h00});
    end
    n = 0;
    for (int k = 0; k < 600 && n < 4; k++) begin
      @(negedge clk);
      if (a.ack0 | a.ack1) n++;
    end
    a.req0 = 0; a.req1 = 0;
    check("contention_acks", n, 4);
    wait_idle(300);
    repeat (3) @(negedge clk);
    a.req0 = 1; a.we0 = 0; a.addr0 = 5'h07; a.wdata0 = 8'h00;
    sbq.push_back('{1'b0, 14'h0007, 8'h00, 8'hFF});
    for (int k = 0; k < 200 && ma_nr != 6; k++) @(negedge clk);
    check("reach_rise6", ma_nr, 6);
    rst = 1'b1; a.req0 = 0;
    sbq.delete();
    @(negedge clk);
    check("abort_cs_n", a.CS_n, 1);
    check("abort_sclk", a.SCLK, 0);
    check("abort_rdata", a.rdata, 0);
    check("abort_no_done", {a.done0, a.done1}, 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    a.req0 = 1; a.we0 = 1; a.addr0 = 5'h04; a.wdata0 = 8'h5A;
    a.req1 = 1; a.we1 = 1; a.addr1 = 5'h08; a.wdata1 = 8'hA5;
    sbq.push_back('{1'b0, 14'h16A4, 8'h00, 8'h00});
    sbq.push_back('{1'b1, 14'h2968, 8'h00, 8'h00});
    @(negedge clk);
    check("rst_favours0", {a.ack1, a.ack0}, 2'b01);
    a.req0 = 0;
    for (int k = 0; k < 200 && !a.ack1; k++) @(negedge clk);
    check("second_ack1", a.ack1, 1);
    a.req1 = 0;
    wait_idle(300);
    repeat (3) @(negedge clk);
    drive('{1'b1, 1'b0, 5'h12, 8'h00, 8'hC3, 14'h0012, 8'hC3});
    @(negedge clk);
    check("short_ack1", a.ack1, 1);
    a.req1 = 0;
    for (int k = 0; k < 200 && ma_nr != 3; k++) @(negedge clk);
    check("reach_rise3", ma_nr, 3);
    a.req0 = 1; a.we0 = 1;
    @(negedge clk);
    a.req0 = 0;
    wait_idle(300);
    repeat (40) @(negedge clk);
    b.req0 = 1; b.we0 = 1; b.addr0 = 5'h05; b.wdata0 = 8'h96;
    for (int k = 0; k < 300 && mb_acks < 3; k++) @(negedge clk);
    b.req0 = 0;
    for (int k = 0; k < 300 && mb_dones < 3; k++) @(negedge clk);
    check("b_frames", mb_dones, 3);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
